// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data access.
// Data wins contention unless fetch has lost STARVE_MAX arbitrations in a row.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [2:0] latCnt_q, latCnt_d;
  logic [3:0] starveCnt_q, starveCnt_d;

  logic complete;
  logic canArb;
  logic ifGnt;
  logic dmGnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      latCnt_q    <= '0;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      latCnt_q    <= latCnt_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // Arbitration is open when idle or on the completion cycle, so a new grant can overlap rvalid.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    latCnt_d    = latCnt_q;
    starveCnt_d = starveCnt_q;
    ifGnt       = 1'b0;
    dmGnt       = 1'b0;

    complete = (state_q == BUSY) && (latCnt_q == LAT);
    canArb   = reset_n && ((state_q == IDLE) || complete);

    if (canArb) begin
      if (bus.dm_req && !(bus.if_req && (starveCnt_q == SMAX))) begin
        dmGnt = 1'b1;
      end else if (bus.if_req) begin
        ifGnt = 1'b1;
      end
    end

    if (ifGnt || dmGnt) begin
      state_d  = BUSY;
      owner_d  = dmGnt ? OWN_DM : OWN_IF;
      latCnt_d = 3'd1;
    end else if (complete) begin
      state_d  = IDLE;
      latCnt_d = 3'd0;
    end else if (state_q == BUSY) begin
      latCnt_d = 3'(latCnt_q + 3'd1);
    end

    if (!bus.if_req || ifGnt) begin
      starveCnt_d = 4'd0;
    end else if (dmGnt && (starveCnt_q != SMAX)) begin
      starveCnt_d = 4'(starveCnt_q + 4'd1);
    end
  end

  always_comb begin
    bus.if_gnt    = ifGnt;
    bus.dm_gnt    = dmGnt;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    if (dmGnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dm_we;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end else if (ifGnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr;
    end

    // Read data is only steered to the owner on its completion cycle.
    bus.if_rvalid = complete && (owner_q == OWN_IF);
    bus.dm_rvalid = complete && (owner_q == OWN_DM);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'd0;
    bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: three arbiter instances with different latency/starvation settings,
// each compared every cycle against a deadline-based reference model.
module tb_mem_port_arbiter;

  localparam int N = 3;

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic int smaxOf(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 1;
  endfunction

  logic clk = 1'b0;
  logic reset_n;

  logic [N-1:0]       ifReqI, dmReqI, dmWeI;
  logic [N-1:0][31:0] ifAddrI, dmAddrI, dmWdataI, memRdataI;

  logic [N-1:0]       ifGntO, dmGntO, ifRvalidO, dmRvalidO, memEnO, memWeO;
  logic [N-1:0][31:0] ifRdataO, dmRdataO, memAddrO, memWdataO;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gInst
    localparam int LAT = latOf(g);
    localparam int SMX = smaxOf(g);

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMX)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );

    assign bus.if_req    = ifReqI[g];
    assign bus.if_addr   = ifAddrI[g];
    assign bus.dm_req    = dmReqI[g];
    assign bus.dm_we     = dmWeI[g];
    assign bus.dm_addr   = dmAddrI[g];
    assign bus.dm_wdata  = dmWdataI[g];
    assign bus.mem_rdata = memRdataI[g];

    assign ifGntO[g]    = bus.if_gnt;
    assign dmGntO[g]    = bus.dm_gnt;
    assign ifRvalidO[g] = bus.if_rvalid;
    assign dmRvalidO[g] = bus.dm_rvalid;
    assign ifRdataO[g]  = bus.if_rdata;
    assign dmRdataO[g]  = bus.dm_rdata;
    assign memEnO[g]    = bus.mem_en;
    assign memWeO[g]    = bus.mem_we;
    assign memAddrO[g]  = bus.mem_addr;
    assign memWdataO[g] = bus.mem_wdata;
  end

  // Reference model: an access is pending until an absolute cycle deadline.
  bit mBusy[N];
  bit mOwnDm[N];
  int mDoneAt[N];
  int mStarve[N];
  bit eIfGnt[N], eDmGnt[N], eComplete[N];
  bit lastIfGnt[N], lastDmGnt[N];
  int cycle = 0;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset(input int k);
    mBusy[k]     = 1'b0;
    mStarve[k]   = 0;
    lastIfGnt[k] = 1'b0;
    lastDmGnt[k] = 1'b0;
  endtask

  // Requesters hold until granted, occasionally withdraw, otherwise re-roll each cycle.
  task automatic applyStimulus(input int k, input int prob);
    if (ifReqI[k] && !lastIfGnt[k]) begin
      if (prob < 90 && $urandom_range(15) == 0) ifReqI[k] = 1'b0;
    end else begin
      ifReqI[k]  = ($urandom_range(99) < prob);
      ifAddrI[k] = $urandom & 32'hFFFF_FFFC;
    end
    if (dmReqI[k] && !lastDmGnt[k]) begin
      if (prob < 90 && $urandom_range(15) == 0) dmReqI[k] = 1'b0;
    end else begin
      dmReqI[k]   = ($urandom_range(99) < prob);
      dmWeI[k]    = 1'($urandom_range(1));
      dmAddrI[k]  = $urandom;
      dmWdataI[k] = $urandom;
    end
    memRdataI[k] = $urandom;
  endtask

  task automatic computeExpected(input int k);
    eComplete[k] = mBusy[k] && (cycle == mDoneAt[k]);
    eIfGnt[k]    = 1'b0;
    eDmGnt[k]    = 1'b0;
    if (!mBusy[k] || eComplete[k]) begin
      if (ifReqI[k] && dmReqI[k]) begin
        if (mStarve[k] == smaxOf(k)) eIfGnt[k] = 1'b1;
        else                         eDmGnt[k] = 1'b1;
      end else if (ifReqI[k]) begin
        eIfGnt[k] = 1'b1;
      end else if (dmReqI[k]) begin
        eDmGnt[k] = 1'b1;
      end
    end
  endtask

  task automatic modelEdge(input int k);
    if (eIfGnt[k] || eDmGnt[k]) begin
      mBusy[k]   = 1'b1;
      mOwnDm[k]  = eDmGnt[k];
      mDoneAt[k] = cycle + latOf(k);
    end else if (eComplete[k]) begin
      mBusy[k] = 1'b0;
    end
    if (!ifReqI[k] || eIfGnt[k]) mStarve[k] = 0;
    else if (eDmGnt[k] && mStarve[k] < smaxOf(k)) mStarve[k]++;
    lastIfGnt[k] = eIfGnt[k];
    lastDmGnt[k] = eDmGnt[k];
  endtask

  task automatic checkCycle(input int k);
    logic [31:0] expAddr, expWdata;
    bit expIfRv, expDmRv;
    expAddr  = eDmGnt[k] ? dmAddrI[k] : (eIfGnt[k] ? ifAddrI[k] : 32'd0);
    expWdata = eDmGnt[k] ? dmWdataI[k] : 32'd0;
    expIfRv  = eComplete[k] && !mOwnDm[k];
    expDmRv  = eComplete[k] && mOwnDm[k];
    checkOutput($sformatf("u%0d.if_gnt", k),    32'(ifGntO[k]),    32'(eIfGnt[k]));
    checkOutput($sformatf("u%0d.dm_gnt", k),    32'(dmGntO[k]),    32'(eDmGnt[k]));
    checkOutput($sformatf("u%0d.mem_en", k),    32'(memEnO[k]),    32'(eIfGnt[k] | eDmGnt[k]));
    checkOutput($sformatf("u%0d.mem_we", k),    32'(memWeO[k]),    32'(eDmGnt[k] & dmWeI[k]));
    checkOutput($sformatf("u%0d.mem_addr", k),  memAddrO[k],       expAddr);
    checkOutput($sformatf("u%0d.mem_wdata", k), memWdataO[k],      expWdata);
    checkOutput($sformatf("u%0d.if_rvalid", k), 32'(ifRvalidO[k]), 32'(expIfRv));
    checkOutput($sformatf("u%0d.dm_rvalid", k), 32'(dmRvalidO[k]), 32'(expDmRv));
    checkOutput($sformatf("u%0d.if_rdata", k),  ifRdataO[k],       expIfRv ? memRdataI[k] : 32'd0);
    checkOutput($sformatf("u%0d.dm_rdata", k),  dmRdataO[k],       expDmRv ? memRdataI[k] : 32'd0);
  endtask

  task automatic checkZero(input int k);
    checkOutput($sformatf("u%0d.rst_gnt", k),    32'({ifGntO[k], dmGntO[k]}),       32'd0);
    checkOutput($sformatf("u%0d.rst_rvalid", k), 32'({ifRvalidO[k], dmRvalidO[k]}), 32'd0);
    checkOutput($sformatf("u%0d.rst_if_rdata", k), ifRdataO[k], 32'd0);
    checkOutput($sformatf("u%0d.rst_dm_rdata", k), dmRdataO[k], 32'd0);
    checkOutput($sformatf("u%0d.rst_mem_en", k), 32'({memEnO[k], memWeO[k]}), 32'd0);
    checkOutput($sformatf("u%0d.rst_mem_addr", k),  memAddrO[k],  32'd0);
    checkOutput($sformatf("u%0d.rst_mem_wdata", k), memWdataO[k], 32'd0);
  endtask

  initial begin
    int prob;
    reset_n   = 1'b1;
    ifReqI    = '0;
    dmReqI    = '0;
    dmWeI     = '0;
    ifAddrI   = '0;
    dmAddrI   = '0;
    dmWdataI  = '0;
    memRdataI = '0;
    for (int k = 0; k < N; k++) modelReset(k);

    #1 reset_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) checkZero(k);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 2500; cyc++) begin
      case ((cyc / 100) % 5)
        0:       prob = 0;
        1:       prob = 40;
        2:       prob = 95;
        3:       prob = 15;
        default: prob = 70;
      endcase
      for (int k = 0; k < N; k++) applyStimulus(k, prob);
      #1;
      for (int k = 0; k < N; k++) begin
        computeExpected(k);
        checkCycle(k);
      end
      if (cyc > 50 && $urandom_range(149) == 0) begin
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
          modelReset(k);
          checkZero(k);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(posedge clk);
        for (int k = 0; k < N; k++) modelEdge(k);
        cycle++;
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the pipeline's instruction-fetch (IF) stage and its data-memory (MEM) stage, for the unified-memory build of the RVX10-P core. One access is in flight at a time. Data accesses have priority, and an anti-starvation counter forces a fetch grant after a bounded number of lost arbitrations. The pipeline's hazard logic stalls each stage while its request is pending and not yet completed.

## Interface
**Parameters**
- `MEM_LAT`, default 1: cycles from issue to read data on `mem_rdata`; legal range 1..4.
- `STARVE_MAX`, default 4: consecutive lost IF arbitrations after which IF wins; legal range 1..15.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_rvalid`  out  1  fetch data valid this cycle.
- `if_rdata`  out  32  fetch data; 0 when `if_rvalid`=0.
- `dm_req`  in  1  data request; held with its qualifiers until `dm_gnt`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  store data.
- `dm_gnt`  out  1  data request accepted this cycle (combinational).
- `dm_rvalid`  out  1  data access complete; set for both reads and writes.
- `dm_rdata`  out  32  load data; 0 when `dm_rvalid`=0.
- `mem_en`  out  1  memory access issued this cycle.
- `mem_we`  out  1  write enable; valid only while `mem_en`=1.
- `mem_addr`  out  32  memory address; 0 when `mem_en`=0.
- `mem_wdata`  out  32  memory write data; 0 when `mem_en`=0.
- `mem_rdata`  in  32  memory read data, valid `MEM_LAT` cycles after issue.

## Operation
**State**
- FSM states: IDLE, BUSY.
- `owner` flag (IF or DM).
- `lat_cnt`, 3 bits.
- `starve_cnt`, 4 bits.

**Arbitration (IDLE, or BUSY on its completion cycle)**
- No request: no grant.
- Only one requester active: that requester is granted.
- Both active: DM is granted unless `starve_cnt` == `STARVE_MAX`, in which case IF is granted.

**Grant cycle**
- Assert the winner's `gnt` and `mem_en`.
- Drive `mem_addr` and `mem_wdata` from the winner.
- `mem_we` = `dm_we` for a DM grant, 0 for an IF grant.
- Next cycle: state is BUSY, `owner` = winner, `lat_cnt` = 1.

**BUSY**
- `lat_cnt` increments each cycle.
- When `lat_cnt` == `MEM_LAT`, it is the completion cycle:
  - assert the owner's `rvalid`;
  - drive the owner's `rdata` = `mem_rdata`;
  - arbitrate again in the same cycle. A new grant keeps the FSM in BUSY with `lat_cnt` = 1; no grant returns it to IDLE.
- Requests arriving during a BUSY cycle that is not a completion cycle wait. No grant is given in those cycles.

**`starve_cnt`**
- Increments, saturating at `STARVE_MAX`, on each DM grant made while `if_req` = 1.
- Clears on any IF grant, and on any cycle with `if_req` = 0.

**Reset**
- Asynchronous assertion forces:
  - IDLE state;
  - all counters 0;
  - all outputs 0 (`gnt`, `rvalid`, `rdata`, `mem_*`).
- An in-flight access is discarded with no `rvalid`.
- Requesters must re-issue after reset.

## Timing
- **Latency:** grant at cycle t gives `rvalid` at t+`MEM_LAT`.
- **Throughput:** peak is one access per `MEM_LAT` cycles. With `MEM_LAT` = 1, back-to-back grants on consecutive cycles are possible.
- **Output timing:** `gnt` and `mem_*` are combinational from `req` and state. `rvalid` depends only on state (registered).
- **Exclusivity:** at most one `gnt` per cycle and at most one `rvalid` per cycle.
- **Request hold:** a requester deasserting `req` before `gnt` withdraws the request, with no side effects.
- **Same-cycle completion and grant:** on a completion cycle the new grant's address appears on `mem_addr` in the same cycle as the completing `rvalid`.

## Test plan
1. **Single fetch.** `MEM_LAT`=2. `if_req` with `if_addr`=0x10 at cycle 3, `mem_rdata` returns 0x00500113.
   - `if_gnt` and `mem_en` at cycle 3.
   - `if_rvalid`=1 at cycle 5 with `if_rdata`=0x00500113.
   - All outputs 0 otherwise.
2. **Contention.** `MEM_LAT`=1. Both requests asserted at the same cycle, `dm_we`=1, `dm_addr`=100, `dm_wdata`=25.
   - DM is granted first: `mem_we`=1, `mem_addr`=100, `mem_wdata`=25.
   - IF is granted on the next cycle.
   - `dm_rvalid` and `if_rvalid` follow on consecutive cycles.
3. **Starvation.** `STARVE_MAX`=4. `if_req` held and `dm_req` held continuously.
   - DM receives exactly 4 grants, then IF receives 1, and the pattern repeats.
   - `starve_cnt` never exceeds 4.
4. **Wait in BUSY.** `MEM_LAT`=3. `dm_req` arrives one cycle after an IF grant.
   - No grant during the 2 intermediate BUSY cycles.
   - `dm_gnt` in the same cycle as `if_rvalid`.
5. **Reset mid-access.** `reset_n` pulled low one cycle after a DM read grant with `MEM_LAT`=2.
   - `dm_rvalid` is never asserted.
   - All outputs read 0 immediately after `reset_n` falls.
   - After release, a new `if_req` is granted in its first cycle.
6. **Idle.** No requests for 20 cycles.
   - `mem_en`=0 and `mem_addr`=0 throughout.
   - `starve_cnt` remains 0.
